// File: rtl/dotp_sched_pkg.sv
// dotp_sched_pkg: shared types and sizing helpers for the dot-product gate scheduler
package dotp_sched_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  function automatic int lw_of(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int dp_lat(input int tree_lat);
    return tree_lat + 1;
  endfunction
endpackage

// File: rtl/dotp_lane_mask.sv
// dotp_lane_mask: lane i all-ones when i < len; lengths beyond LEN clip naturally since only LEN lanes exist
module dotp_lane_mask #(
  parameter int WIDTH = 16,
  parameter int LEN = 8,
  parameter int LW = 4
) (
  input  logic [LW-1:0]        len,
  output logic [LEN*WIDTH-1:0] mask
);
  for (genvar g = 0; g < LEN; g++) begin : g_lane
    assign mask[g*WIDTH +: WIDTH] = {WIDTH{len > LW'(g)}};
  end
endmodule

// File: rtl/dotp_gate_scheduler.sv
// dotp_gate_scheduler: round-robin issue of two requesters onto a shared gated dot-product datapath.
// Define DOTP_SCHED_PERF_EN to add saturating accept/idle performance counters.
module dotp_gate_scheduler
  import dotp_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN = 8,
  parameter int TREE_LAT = 3,
  localparam int LW = lw_of(LEN),
  localparam int DP_LAT = dp_lat(TREE_LAT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [LW-1:0]        req0_len,
  input  logic [LEN*WIDTH-1:0] req0_vec1,
  input  logic [LEN*WIDTH-1:0] req0_vec2,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [LW-1:0]        req1_len,
  input  logic [LEN*WIDTH-1:0] req1_vec1,
  input  logic [LEN*WIDTH-1:0] req1_vec2,
  output logic [LEN*WIDTH-1:0] dp_vec1,
  output logic [LEN*WIDTH-1:0] dp_vec2,
  output logic [LEN*WIDTH-1:0] dp_mult_out_en,
  input  logic [WIDTH-1:0]     dp_dotp_out,
  output logic                 res_valid,
  output logic                 res_id,
  output logic [WIDTH-1:0]     res_data,
  input  logic                 drain_req,
  output logic                 drain_done
`ifdef DOTP_SCHED_PERF_EN
  ,
  output logic [15:0]          perf_cnt0,
  output logic [15:0]          perf_cnt1,
  output logic [15:0]          perf_idle
`endif
);
  state_t state, state_nx;
  logic ptr, run, acc, win;
  logic [DP_LAT:0] tv, ti;
  logic [LEN*WIDTH-1:0] mask;
  // reset gates readiness so every output reads 0 while reset is held
  assign run = reset && state == RUN && !drain_req;
  assign req1_ready = run && req1_valid && (!req0_valid || ptr);
  assign req0_ready = run && req0_valid && !req1_ready;
  assign acc = req0_ready || req1_ready;
  assign win = req1_ready;
  dotp_lane_mask #(.WIDTH(WIDTH), .LEN(LEN), .LW(LW)) u_mask (
    .len(win ? req1_len : req0_len),
    .mask(mask)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dp_vec1 <= '0;
      dp_vec2 <= '0;
      dp_mult_out_en <= '0;
      ptr <= 1'b0;
      tv <= '0;
      ti <= '0;
    end else begin
      dp_vec1 <= acc ? (win ? req1_vec1 : req0_vec1) : '0;
      dp_vec2 <= acc ? (win ? req1_vec2 : req0_vec2) : '0;
      dp_mult_out_en <= acc ? mask : '0;
      ptr <= ptr ^ acc;
      tv <= {tv[DP_LAT-1:0], acc};
      ti <= {ti[DP_LAT-1:0], win};
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nx;
  // DONE once the pipe is empty after this edge, so drain_done follows the last result by one cycle
  always_comb begin
    state_nx = state;
    state_nx = state == RUN ? (drain_req ? DRAIN : RUN)
             : !drain_req ? RUN
             : (state == DRAIN && tv[DP_LAT-1:0] == '0) ? DONE : state;
  end
  assign res_valid = tv[DP_LAT];
  assign res_id = ti[DP_LAT];
  assign res_data = res_valid ? dp_dotp_out : '0;
  assign drain_done = state == DONE;
`ifdef DOTP_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
      perf_idle <= '0;
    end else begin
      if (req0_ready && perf_cnt0 != '1) perf_cnt0 <= perf_cnt0 + 16'd1;
      if (req1_ready && perf_cnt1 != '1) perf_cnt1 <= perf_cnt1 + 16'd1;
      if (state == RUN && !acc && perf_idle != '1) perf_idle <= perf_idle + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dotp_gate_scheduler.sv
// tb_dotp_gate_scheduler: randomized bench with a Q8.8 datapath stand-in and a queue-based result model.
// Define DOTP_SCHED_PERF_EN to also check the performance counters.
module tb_dotp_gate_scheduler;
  localparam int WIDTH = 16, LEN = 8, TREE_LAT = 3, DP_LAT = TREE_LAT + 1, VW = LEN * WIDTH;
  logic clk = 0, reset = 0;
  logic req0_valid = 0, req1_valid = 0, drain_req = 0;
  logic req0_ready, req1_ready, res_valid, res_id, drain_done;
  logic [3:0] req0_len = 0, req1_len = 0;
  logic [VW-1:0] req0_vec1 = 0, req0_vec2 = 0, req1_vec1 = 0, req1_vec2 = 0;
  logic [VW-1:0] dp_vec1, dp_vec2, dp_mult_out_en;
  logic [WIDTH-1:0] dp_dotp_out, res_data;
  logic [DP_LAT*WIDTH-1:0] dpp;
`ifdef DOTP_SCHED_PERF_EN
  logic [15:0] perf_cnt0, perf_cnt1, perf_idle;
  int m_cnt0, m_cnt1, m_idle;
`endif
  typedef struct {int due; bit id; logic [15:0] data;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, mode_m = 0;
  bit ptr_m = 0;

  always #5 clk = ~clk;

  dotp_gate_scheduler #(.WIDTH(WIDTH), .LEN(LEN), .TREE_LAT(TREE_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_len(req0_len),
    .req0_vec1(req0_vec1), .req0_vec2(req0_vec2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_len(req1_len),
    .req1_vec1(req1_vec1), .req1_vec2(req1_vec2),
    .dp_vec1(dp_vec1), .dp_vec2(dp_vec2), .dp_mult_out_en(dp_mult_out_en),
    .dp_dotp_out(dp_dotp_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .drain_req(drain_req), .drain_done(drain_done)
`ifdef DOTP_SCHED_PERF_EN
    , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1), .perf_idle(perf_idle)
`endif
  );

  // Stand-in datapath: masked Q8.8 lane products summed, DP_LAT registers from dp_* to dotp_out
  function automatic logic [15:0] dp_model(logic [VW-1:0] a, logic [VW-1:0] b, logic [VW-1:0] m);
    int s = 0;
    for (int i = 0; i < LEN; i++)
      s += ((int'($signed(a[i*16 +: 16])) * int'($signed(b[i*16 +: 16]))) >>> 8) & int'($signed(m[i*16 +: 16]));
    return s[15:0];
  endfunction

  always_ff @(posedge clk or negedge reset)
    if (!reset) dpp <= '0;
    else dpp <= {dpp[(DP_LAT-1)*WIDTH-1:0], dp_model(dp_vec1, dp_vec2, dp_mult_out_en)};
  assign dp_dotp_out = dpp[DP_LAT*WIDTH-1 -: WIDTH];

  function automatic logic [15:0] ref_dot(logic [VW-1:0] a, logic [VW-1:0] b, logic [3:0] len);
    int n = len > LEN ? LEN : int'(len);
    int s = 0;
    for (int i = 0; i < n; i++)
      s += (int'($signed(a[i*16 +: 16])) * int'($signed(b[i*16 +: 16]))) >>> 8;
    return s[15:0];
  endfunction

  function automatic logic [VW-1:0] rv();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string tag, logic [VW-1:0] got, logic [VW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the model across the edge
  task automatic tick();
    bit run, a0, a1;
    @(negedge clk);
    run = mode_m == 0 && !drain_req;
    a1 = run && req1_valid && (!req0_valid || ptr_m);
    a0 = run && req0_valid && !a1;
    chk("ready0", req0_ready, a0);
    chk("ready1", req1_ready, a1);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("res_valid", res_valid, 1);
      chk("res_id", res_id, q[0].id);
      chk("res_data", res_data, q[0].data);
      void'(q.pop_front());
    end else chk("res_valid", res_valid, 0);
    chk("drain_done", drain_done, mode_m == 2);
`ifdef DOTP_SCHED_PERF_EN
    chk("perf_cnt0", perf_cnt0, m_cnt0);
    chk("perf_cnt1", perf_cnt1, m_cnt1);
    chk("perf_idle", perf_idle, m_idle);
    if (a0 && m_cnt0 < 65535) m_cnt0++;
    if (a1 && m_cnt1 < 65535) m_cnt1++;
    if (mode_m == 0 && !a0 && !a1 && m_idle < 65535) m_idle++;
`endif
    if (a0) q.push_back('{cyc + 1 + DP_LAT, 1'b0, ref_dot(req0_vec1, req0_vec2, req0_len)});
    if (a1) q.push_back('{cyc + 1 + DP_LAT, 1'b1, ref_dot(req1_vec1, req1_vec2, req1_len)});
    if (a0 || a1) ptr_m = !ptr_m;
    if (mode_m == 0) mode_m = drain_req ? 1 : 0;
    else if (!drain_req) mode_m = 0;
    else if (q.size() == 0) mode_m = 2;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    req0_valid = 1;
    req1_valid = 1;
    drain_req = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_drain_done", drain_done, 0);
      chk("rst_dp_vec1", dp_vec1, 0);
      chk("rst_dp_mask", dp_mult_out_en, 0);
    end
    @(posedge clk);
    #1;
    reset = 1;
    req0_valid = 0;
    req1_valid = 0;
    q.delete();
    ptr_m = 0;
    mode_m = 0;
`ifdef DOTP_SCHED_PERF_EN
    m_cnt0 = 0;
    m_cnt1 = 0;
    m_idle = 0;
`endif
  endtask

  initial begin
    do_reset();
    // single req0, eight lanes of 1.0 -> 8.0
    req0_valid = 1; req0_len = 8; req0_vec1 = {8{16'h0100}}; req0_vec2 = {8{16'h0100}};
    chk("t1_ref", ref_dot(req0_vec1, req0_vec2, req0_len), 16'h0800);
    tick();
    req0_valid = 0;
    repeat (6) tick();
    // both requesters contending: alternating grants, in-order results
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req0_vec1 = rv(); req0_vec2 = rv(); req1_vec1 = rv(); req1_vec2 = rv();
      req0_len = 4'($urandom_range(0, 8)); req1_len = 4'($urandom_range(0, 8));
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (6) tick();
    // mask shapes: partial, empty, clipped
    req0_valid = 1; req0_vec1 = {8{16'h0100}}; req0_vec2 = {8{16'h0100}};
    req0_len = 3; tick();
    chk("mask_len3", dp_mult_out_en, {80'h0, 48'hFFFF_FFFF_FFFF});
    req0_len = 0; tick();
    chk("mask_len0", dp_mult_out_en, 0);
    req0_len = 15; tick();
    chk("mask_len15", dp_mult_out_en, {VW{1'b1}});
    req0_valid = 0; tick();
    chk("mask_idle", dp_mult_out_en, 0);
    repeat (6) tick();
    // drain with three ops in flight and a competing new request
    req0_valid = 1;
    repeat (3) begin req0_vec1 = rv(); req0_vec2 = rv(); req0_len = 4'($urandom); tick(); end
    drain_req = 1; req1_valid = 1;
    repeat (10) tick();
    req0_valid = 0; req1_valid = 0; drain_req = 0;
    repeat (3) tick();
    // reset with two ops in flight discards them
    req1_valid = 1;
    repeat (2) begin req1_vec1 = rv(); req1_vec2 = rv(); req1_len = 4'($urandom); tick(); end
    do_reset();
    repeat (8) tick();
    // randomized traffic with occasional drain requests
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom % 3) != 0; req1_valid = ($urandom % 3) != 0;
      req0_vec1 = rv(); req0_vec2 = rv(); req1_vec1 = rv(); req1_vec2 = rv();
      req0_len = 4'($urandom); req1_len = 4'($urandom);
      if ($urandom % 20 == 0) drain_req = !drain_req;
      tick();
    end
    req0_valid = 0; req1_valid = 0; drain_req = 0;
    repeat (8) tick();
    chk("queue_empty", q.size(), 0);
`ifdef DOTP_SCHED_PERF_EN
    do_reset();
    req1_valid = 1;
    repeat (10) tick();
    req1_valid = 0;
    repeat (5) tick();
    chk("perf1_total", perf_cnt1, 10);
    chk("perf0_total", perf_cnt0, 0);
    chk("perf_idle_total", perf_idle, 5);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
